// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, defaults, state encodings and slot entry type for the fetch stage
package if_fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   typedef enum logic [2:0] {
      FETCH_IDLE,
      FETCH_REQ,
      FETCH_WAIT,
      FETCH_DROP,
      FETCH_STALL
   } fetch_state_e;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            err;
   } fetch_ent_t;
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~32'h3;
   endfunction
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction bus between the fetch stage (master) and memory (slave)
interface if_fetch_if;
   import if_fetch_pkg::*;
   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;
   logic            err;
   modport master(output req, addr, input gnt, rvalid, rdata, err);
   modport slave(input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/if_fetch_skid_buf.sv
// if_fetch_skid_buf: one-entry {pc, inst, err} holding buffer for responses that find the slot occupied
module if_fetch_skid_buf
   import if_fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  fetch_ent_t din,
   output fetch_ent_t dout,
   output logic       full
);
   always_ff @(posedge clk) begin
      if (!rst_n || flush) full <= 1'b0;
      else if (push) full <= 1'b1;
      else if (pop) full <= 1'b0;
   end
   always_ff @(posedge clk) if (push) dout <= din;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC owner issuing single-outstanding instruction reads into the IF/ID slot,
// with jump redirect, downstream hold, stale-response discard and a one-entry skid.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [XLEN-1:0] NOP_INST = INST_NOP
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            jump_en,
   input  logic [XLEN-1:0] jump_addr,
   input  logic            hold,
   if_fetch_if.master      ibus,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_inst,
   output logic            if_valid,
   output logic            if_err
);
   fetch_state_e    state, nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            consume, resp, push, pop, skid_full;
   fetch_ent_t      rsp, skid;
   assign consume = if_valid && !hold;
   assign resp    = state == FETCH_WAIT && ibus.rvalid && !jump_en;
   assign push    = resp && if_valid && !consume;
   assign pop     = consume && skid_full && !jump_en;
   assign pc_nxt  = jump_en ? word_align(jump_addr) : (state == FETCH_REQ && ibus.gnt) ? pc + 32'd4 : pc;
   // the address register still holds the granted address while waiting, so it tags the response
   assign rsp = '{pc: ibus.addr, inst: ibus.err ? NOP_INST : ibus.rdata, err: ibus.err};
   always_comb begin
      nxt = state;
      case (state)
         FETCH_IDLE:  nxt = FETCH_REQ;
         FETCH_REQ:   nxt = !ibus.gnt ? FETCH_REQ : jump_en ? FETCH_DROP : FETCH_WAIT;
         FETCH_WAIT:  nxt = ibus.rvalid ? (push ? FETCH_STALL : FETCH_REQ) : jump_en ? FETCH_DROP : FETCH_WAIT;
         FETCH_DROP:  nxt = ibus.rvalid ? FETCH_REQ : FETCH_DROP;
         FETCH_STALL: nxt = (jump_en || pop || !skid_full) ? FETCH_REQ : FETCH_STALL;
         default:     nxt = FETCH_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= FETCH_IDLE;
         pc        <= RESET_PC;
         ibus.req  <= 1'b0;
         ibus.addr <= RESET_PC;
      end else begin
         state    <= nxt;
         pc       <= pc_nxt;
         ibus.req <= nxt == FETCH_REQ;
         if (nxt == FETCH_REQ) ibus.addr <= pc_nxt;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_pc    <= RESET_PC;
         if_inst  <= NOP_INST;
         if_valid <= 1'b0;
         if_err   <= 1'b0;
      end else if (jump_en) begin
         if_inst  <= NOP_INST;
         if_valid <= 1'b0;
         if_err   <= 1'b0;
      end else if (resp && (!if_valid || consume)) begin
         {if_pc, if_inst, if_err} <= rsp;
         if_valid <= 1'b1;
      end else if (pop) begin
         {if_pc, if_inst, if_err} <= skid;
         if_valid <= 1'b1;
      end else if (consume) begin
         if_inst  <= NOP_INST;
         if_valid <= 1'b0;
         if_err   <= 1'b0;
      end
   end
   if_fetch_skid_buf u_skid (
      .clk(clk),
      .rst_n(rst_n),
      .push(push),
      .pop(pop),
      .flush(jump_en),
      .din(rsp),
      .dout(skid),
      .full(skid_full)
   );
endmodule
